// File: rtl/timer_capture_if.sv
// Peripheral bus bundle shared by the timer-family blocks.
interface timer_capture_if;
  logic        req;
  logic        we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/timer_capture.sv
// Input-capture timer: a free-running 32-bit counter is latched into CAPR on a
// selected edge of the synchronized cap_in pin, with status, W1C interrupt
// flags and a registered level interrupt.
module timer_capture #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  timer_capture_if.slave  bus,
  input  logic            cap_in,
  output logic            irq
);

  logic [31:0]            cnt_q,    cnt_d;
  logic [31:0]            capr_q,   capr_d;
  logic                   cr_en_q,  cr_en_d;
  logic [1:0]             cr_edg_q, cr_edg_d;
  logic                   vld_q,    vld_d;
  logic                   ovr_q,    ovr_d;
  logic [1:0]             ier_q,    ier_d;
  logic [1:0]             isr_q,    isr_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   irq_q;
  logic                   rvalid_q;
  logic [31:0]            rdata_q,  rdata_d;

  logic        wr, rd;
  logic        wr_cr, wr_cntr, wr_ier, wr_isr, rd_capr;
  logic        rise, fall, cap;
  logic [31:0] rd_mux;

  assign wr      = bus.req &  bus.we;
  assign rd      = bus.req & ~bus.we;
  assign wr_cr   = wr && (bus.addr == 12'h000);
  assign wr_cntr = wr && (bus.addr == 12'h008);
  assign wr_ier  = wr && (bus.addr == 12'h010);
  assign wr_isr  = wr && (bus.addr == 12'h014);
  assign rd_capr = rd && (bus.addr == 12'h00C);

  // Edge detect between the last synchronizer stage and the history flop.
  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;
  assign cap  = cr_en_q & ((cr_edg_q[0] & rise) | (cr_edg_q[1] & fall));

  // Counter next value: clr beats a CNTR load, which beats counting.
  always_comb begin
    cnt_d = cnt_q;
    if (cr_en_q) cnt_d = cnt_q + 32'd1;
    if (wr_cntr) cnt_d = bus.wdata;
    if (wr_cr && bus.wdata[3]) cnt_d = '0;
  end

  // Control registers written from the bus; clr is never stored.
  always_comb begin
    cr_en_d  = cr_en_q;
    cr_edg_d = cr_edg_q;
    ier_d    = ier_q;
    if (wr_cr) begin
      cr_en_d  = bus.wdata[0];
      cr_edg_d = bus.wdata[2:1];
    end
    if (wr_ier) ier_d = bus.wdata[1:0];
  end

  // Capture, status and flag updates. A capture coinciding with a CAPR read
  // keeps vld set and leaves ovr untouched; hardware flag sets beat W1C.
  always_comb begin
    capr_d = capr_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    isr_d  = isr_q;
    if (wr_isr) isr_d = isr_q & ~bus.wdata[1:0];
    if (rd_capr) begin
      vld_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (cap) begin
      capr_d   = cnt_q;
      vld_d    = 1'b1;
      isr_d[0] = 1'b1;
      if (rd_capr) begin
        ovr_d = ovr_q;
      end else if (vld_q) begin
        ovr_d    = 1'b1;
        isr_d[1] = 1'b1;
      end
    end
  end

  // Read data mux; unmapped offsets and reserved bits return zero.
  always_comb begin
    rd_mux = '0;
    unique case (bus.addr)
      12'h000: rd_mux = {29'd0, cr_edg_q, cr_en_q};
      12'h004: rd_mux = {30'd0, ovr_q, vld_q};
      12'h008: rd_mux = cnt_q;
      12'h00C: rd_mux = capr_q;
      12'h010: rd_mux = {30'd0, ier_q};
      12'h014: rd_mux = {30'd0, isr_q};
      default: rd_mux = '0;
    endcase
    rdata_d = rd ? rd_mux : '0;
  end

  // All state, including the synchronizer chain, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      capr_q   <= '0;
      cr_en_q  <= 1'b0;
      cr_edg_q <= '0;
      vld_q    <= 1'b0;
      ovr_q    <= 1'b0;
      ier_q    <= '0;
      isr_q    <= '0;
      sync_q   <= '0;
      hist_q   <= 1'b0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      capr_q   <= capr_d;
      cr_en_q  <= cr_en_d;
      cr_edg_q <= cr_edg_d;
      vld_q    <= vld_d;
      ovr_q    <= ovr_d;
      ier_q    <= ier_d;
      isr_q    <= isr_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], cap_in};
      hist_q   <= sync_q[SYNC_STAGES-1];
      irq_q    <= |(isr_q & ier_q);
      rvalid_q <= bus.req;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.gnt    = bus.req;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_timer_capture.sv
// Directed bench for timer_capture: register map, capture timing, edge
// selection, overrun, counter wrap/clear, simultaneous read/capture, reset.
module tb_timer_capture;

  logic clk = 1'b0;
  logic rst_n;
  logic cap_in;
  logic irq;
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [11:0] CR   = 12'h000;
  localparam logic [11:0] SR   = 12'h004;
  localparam logic [11:0] CNTR = 12'h008;
  localparam logic [11:0] CAPR = 12'h00C;
  localparam logic [11:0] IER  = 12'h010;
  localparam logic [11:0] ISR  = 12'h014;

  timer_capture_if bus_if ();

  timer_capture #(.SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus_if),
    .cap_in (cap_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands at the following posedge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.wdata = d;
    @(negedge clk);
    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
  endtask

  // Called at a negedge; the response is sampled at the next negedge.
  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
    @(negedge clk);
    chk("rvalid", {31'd0, bus_if.rvalid}, 32'd1);
    d = bus_if.rdata;
    bus_if.req = 1'b0; bus_if.addr = '0;
  endtask

  task automatic rdc(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] t1, t2;
    rst_n = 1'b0; cap_in = 1'b0;
    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    idle(3);
    rst_n = 1'b1;

    // 1: reset state
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rvalid", {31'd0, bus_if.rvalid}, 32'd0);
    rdc("rst_cr", CR, 32'h0);
    rdc("rst_sr", SR, 32'h0);
    rdc("rst_cntr", CNTR, 32'h0);
    rdc("rst_capr", CAPR, 32'h0);
    rdc("rst_ier", IER, 32'h0);
    rdc("rst_isr", ISR, 32'h0);
    idle(1);
    chk("rvalid_drop", {31'd0, bus_if.rvalid}, 32'd0);

    // 2: basic rising capture at counter 100
    wr(CNTR, 32'd100);
    wr(IER, 32'h1);
    wr(CR, 32'h3);
    cap_in = 1'b1;
    idle(3);
    chk("irq_lat", {31'd0, irq}, 32'd0);
    rdc("cap1_sr", SR, 32'h1);
    chk("irq_set", {31'd0, irq}, 32'd1);
    rdc("cap1_isr", ISR, 32'h1);
    rdc("cap1_capr", CAPR, 32'd102);
    rdc("cap1_sr_clr", SR, 32'h0);
    wr(ISR, 32'h1);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    idle(1);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rdc("isr_w1c", ISR, 32'h0);

    // 3: overrun from two unread captures
    cap_in = 1'b0; idle(4);
    wr(CNTR, 32'h1000); cap_in = 1'b1; idle(4);
    cap_in = 1'b0; idle(4);
    wr(CNTR, 32'h2000); cap_in = 1'b1; idle(4);
    rdc("ovr_sr", SR, 32'h3);
    rdc("ovr_isr", ISR, 32'h3);
    rdc("ovr_capr", CAPR, 32'h2002);
    rdc("ovr_sr_clr", SR, 32'h0);
    wr(ISR, 32'h3);

    // 4: edge selection
    cap_in = 1'b0; idle(4);
    rdc("rise_only_fall", SR, 32'h0);
    wr(CR, 32'h5);
    cap_in = 1'b1; idle(4);
    rdc("fall_only_rise", SR, 32'h0);
    wr(CNTR, 32'h3000); cap_in = 1'b0; idle(4);
    rdc("fall_sr", SR, 32'h1);
    rdc("fall_capr", CAPR, 32'h3002);
    wr(ISR, 32'h3);
    wr(CR, 32'h7);
    wr(CNTR, 32'h4000); cap_in = 1'b1; idle(4);
    cap_in = 1'b0;
    rd(CAPR, t1);
    chk("both_first", t1, 32'h4002);
    idle(2);
    rdc("both_sr", SR, 32'h1);
    rd(CAPR, t2);
    chk("both_second", t2, 32'h4006);
    chk("both_diff", t2 - t1, 32'd4);
    wr(ISR, 32'h3);
    wr(CR, 32'h1);
    cap_in = 1'b1; idle(4);
    cap_in = 1'b0; idle(4);
    rdc("none_sr", SR, 32'h0);
    rdc("none_isr", ISR, 32'h0);

    // 5: wrap, clear, unmapped
    wr(CNTR, 32'hFFFF_FFFE);
    rdc("wrap0", CNTR, 32'hFFFF_FFFE);
    rdc("wrap1", CNTR, 32'hFFFF_FFFF);
    rdc("wrap2", CNTR, 32'h0000_0000);
    wr(CNTR, 32'h55);
    wr(CR, 32'h9);
    rdc("clr_cntr", CNTR, 32'h0);
    rdc("clr_reads0", CR, 32'h1);
    rdc("unmapped_rd", 12'h100, 32'h0);
    wr(12'h030, 32'h2);
    rdc("unmapped_wr", IER, 32'h1);

    // 6: capture coincident with CAPR read
    wr(CR, 32'h3);
    wr(CNTR, 32'h5000); cap_in = 1'b1; idle(4);
    cap_in = 1'b0; idle(4);
    wr(CNTR, 32'h6000); cap_in = 1'b1; idle(2);
    rdc("coinc_old", CAPR, 32'h5002);
    rdc("coinc_sr", SR, 32'h1);
    rdc("coinc_new", CAPR, 32'h6002);

    // 6: reset mid-synchronization
    cap_in = 1'b0; idle(4);
    wr(IER, 32'h3);
    cap_in = 1'b1; idle(1);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    rst_n = 1'b0; idle(1);
    chk("in_rst_irq", {31'd0, irq}, 32'd0);
    chk("in_rst_rvalid", {31'd0, bus_if.rvalid}, 32'd0);
    rst_n = 1'b1; idle(4);
    rdc("rel_cr", CR, 32'h0);
    rdc("rel_sr", SR, 32'h0);
    rdc("rel_cntr", CNTR, 32'h0);
    rdc("rel_capr", CAPR, 32'h0);
    rdc("rel_ier", IER, 32'h0);
    rdc("rel_isr", ISR, 32'h0);
    chk("rel_irq", {31'd0, irq}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
